// File: rtl/program_loader_pkg.sv
// Shared definitions for the host-link program loader: command bytes,
// FSM state encoding and address sizing.
package program_loader_pkg;

    localparam int ADDR_W         = 10;
    localparam int CNT_W          = 10;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [7:0] CMD_LOAD_INSTR = 8'hA5;
    localparam logic [7:0] CMD_LOAD_DATA  = 8'h5A;
    localparam logic [7:0] CMD_RUN        = 8'hF0;
    localparam logic [7:0] CMD_HALT       = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } state_e;

    function automatic logic state_busy(input state_e s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four accepted bytes MSB-first into a 32-bit word and pulses
// word_done_o in the same cycle the fourth byte is accepted.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    // Only the first three bytes need storage; the fourth is passed straight
    // through so the completed word is available on the accepting edge.
    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Host-link program loader: parses load/run commands, writes assembled words
// into CPU instruction or data memory and controls the CPU reset.
module program_loader #(
    parameter int ADDR_W = program_loader_pkg::ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] address,
    output logic              write_instruction,
    output logic              write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              error
);
    import program_loader_pkg::*;

    state_e              state_q, state_d;
    logic                target_instr_q, target_instr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_instr_q, wr_instr_d;
    logic                wr_data_q, wr_data_d;
    logic                cpu_rst_q, busy_q, error_q, in_ready_q;

    logic                accept;
    logic                asm_clear;
    logic [31:0]         asm_word;
    logic                asm_done;

    assign accept = in_valid && in_ready_q;

    word_assembler u_word_assembler (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (asm_clear),
        .byte_valid_i (accept && (state_q == ST_DATA)),
        .byte_i       (in_byte),
        .word_o       (asm_word),
        .word_done_o  (asm_done)
    );

    always_comb begin
        state_d        = state_q;
        target_instr_d = target_instr_q;
        count_d        = count_q;
        addr_d         = addr_q;
        data_d         = data_q;
        wr_instr_d     = 1'b0;
        wr_data_d      = 1'b0;
        asm_clear      = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (in_byte == CMD_LOAD_INSTR) begin
                    target_instr_d = 1'b1;
                    state_d        = ST_CNT_HI;
                end else if (in_byte == CMD_LOAD_DATA) begin
                    target_instr_d = 1'b0;
                    state_d        = ST_CNT_HI;
                end else if (in_byte == CMD_RUN) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_CNT_HI: if (accept) begin
                if (in_byte[7:2] != 6'd0) begin
                    state_d = ST_ERR;
                end else begin
                    count_d[9:8] = in_byte[1:0];
                    state_d      = ST_CNT_LO;
                end
            end
            ST_CNT_LO: if (accept) begin
                count_d[7:0] = in_byte;
                addr_d       = '0;
                asm_clear    = 1'b1;
                state_d      = ST_DATA;
            end
            ST_DATA: if (asm_done) begin
                data_d     = DATA_W'(asm_word);
                wr_instr_d = target_instr_q;
                wr_data_d  = !target_instr_q;
                state_d    = ST_WRITE;
            end
            // count holds words still to go after this one, so the address never wraps
            ST_WRITE: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
            ST_RUN: if (accept && (in_byte == CMD_HALT)) state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            target_instr_q <= 1'b0;
            count_q        <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            wr_instr_q     <= 1'b0;
            wr_data_q      <= 1'b0;
            cpu_rst_q      <= 1'b1;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            in_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_instr_q <= target_instr_d;
            count_q        <= count_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            wr_instr_q     <= wr_instr_d;
            wr_data_q      <= wr_data_d;
            cpu_rst_q      <= (state_d != ST_RUN);
            busy_q         <= state_busy(state_d);
            error_q        <= (state_d == ST_ERR);
            in_ready_q     <= (state_d != ST_WRITE);
        end
    end

    assign in_ready          = in_ready_q;
    assign inst_data         = data_q;
    assign address           = addr_q;
    assign write_instruction = wr_instr_q;
    assign write_data        = wr_data_q;
    assign cpu_rst           = cpu_rst_q;
    assign busy              = busy_q;
    assign error             = error_q;

endmodule
